rom_download_bridge: RTL and testbench

Parametrised successor to the inline ioctl-to-DDRAM write path in the core top level. It buffers cartridge download words from hps_io in a small FIFO and issues them to the ROM memory controller over a toggle req/ack handshake. It throttles hps_io via `ioctl_wait`, optionally byte-swaps data, and tracks the loaded ROM size. It reports overflow and download completion. It sits between `hps_io` and `ddram`, replacing the single-entry write logic.

---
 rtl/rom_download_bridge_if.sv | 26 ++
 rtl/rom_download_bridge.sv | 133 +++++++++++++
 tb/tb_rom_download_bridge.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_download_bridge_if.sv
// Bus bundle between hps_io (ioctl side) and the ROM memory controller (toggle req/ack side).
// The bridge uses the slave view; the environment (hps_io + memory model) uses the master view.
interface rom_download_bridge_if #(
    parameter int AW = 25,
    parameter int DW = 16
);
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [DW-1:0] ioctl_data;
    logic          ioctl_wait;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_req;
    logic          wr_ack;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, wr_ack,
        input  ioctl_wait, wr_addr, wr_data, wr_req
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, wr_ack,
        output ioctl_wait, wr_addr, wr_data, wr_req
    );
endinterface

// File: rtl/rom_download_bridge.sv
// Buffers ioctl download words in a small FIFO and issues them to the ROM memory
// controller over a toggle req/ack handshake; tracks loaded size, overflow and completion.
//
//   state  | meaning
//   S_IDLE | no write outstanding; may issue FIFO head when wr_req == wr_ack
//   S_BUSY | write issued; waiting for wr_ack to match wr_req
module rom_download_bridge #(
    parameter int AW    = 25,
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter bit SWAP  = 1'b1
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    rom_download_bridge_if.slave  bus,
    output logic [AW-1:0]         rom_size,
    output logic                  overflow,
    output logic                  done
);
    localparam int              PW         = $clog2(DEPTH);
    localparam int              NB         = DW / 8;
    localparam logic [AW-1:0]   WORD_BYTES = AW'(NB);
    localparam logic [PW:0]     FULL_CNT   = (PW+1)'(DEPTH);
    localparam logic [PW:0]     WAIT_CNT   = (PW+1)'(DEPTH - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        state, state_next;

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] head, tail, head_base, tail_base;
    logic [PW:0]   count, count_base, count_next;
    logic          dl_prev, dl_rise;
    logic          done_armed, done_cond;
    logic          push, pop, full_base, empty_base;
    logic [AW-1:0] push_end, rom_size_base;
    logic [DW-1:0] push_data;

    function automatic logic [DW-1:0] byte_swap(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            r[8*i +: 8] = d[DW-8-8*i +: 8];
        end
        return r;
    endfunction

    // A download rising edge restarts the FIFO and size tracking in the same cycle,
    // so a strobe coincident with the edge lands in a freshly emptied FIFO.
    always_comb begin
        dl_rise       = bus.ioctl_download & ~dl_prev;
        head_base     = dl_rise ? '0 : head;
        tail_base     = dl_rise ? '0 : tail;
        count_base    = dl_rise ? '0 : count;
        rom_size_base = dl_rise ? '0 : rom_size;
        full_base     = (count_base == FULL_CNT);
        empty_base    = (count_base == '0);
        push          = bus.ioctl_wr & ~full_base;
        push_end      = bus.ioctl_addr + WORD_BYTES;
        push_data     = SWAP ? byte_swap(bus.ioctl_data) : bus.ioctl_data;
        done_cond     = done_armed & ~bus.ioctl_download & (count == '0) &
                        (state == S_IDLE) & (bus.wr_req == bus.wr_ack);
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty_base && (bus.wr_req == bus.wr_ack)) begin
                    pop        = 1'b1;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.wr_req == bus.wr_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        count_next = count_base + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[tail_base] <= bus.ioctl_addr;
            fifo_data[tail_base] <= push_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state          <= S_IDLE;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            dl_prev        <= 1'b0;
            done_armed     <= 1'b0;
            done           <= 1'b0;
            overflow       <= 1'b0;
            rom_size       <= '0;
            bus.ioctl_wait <= 1'b0;
            bus.wr_req     <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
        end else begin
            state          <= state_next;
            dl_prev        <= bus.ioctl_download;
            head           <= head_base + PW'(pop);
            tail           <= tail_base + PW'(push);
            count          <= count_next;
            bus.ioctl_wait <= (count_next >= WAIT_CNT);
            overflow       <= (dl_rise ? 1'b0 : overflow) | (bus.ioctl_wr & full_base);
            if (push && (push_end > rom_size_base)) begin
                rom_size <= push_end;
            end else begin
                rom_size <= rom_size_base;
            end
            if (pop) begin
                bus.wr_addr <= fifo_addr[head_base];
                bus.wr_data <= fifo_data[head_base];
                bus.wr_req  <= ~bus.wr_req;
            end
            done       <= done_cond;
            done_armed <= dl_rise | (done_armed & ~done_cond);
        end
    end
endmodule

// File: tb/tb_rom_download_bridge.sv
// Randomised bench for rom_download_bridge: drives hps_io-style strobes, models the
// memory side as a delayed toggle-ack responder and checks writes against a word-level model.
module tb_rom_download_bridge;
    localparam int AW    = 25;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic [AW-1:0] rom_size;
    logic          overflow;
    logic          done;

    rom_download_bridge_if #(.AW(AW), .DW(DW)) bus ();

    rom_download_bridge #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .SWAP(1'b1)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .bus      (bus),
        .rom_size (rom_size),
        .overflow (overflow),
        .done     (done)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory responder: logs each new request and returns the ack ack_lat cycles later.
    int            ack_lat  = 0;
    bit            mem_hold = 1'b0;
    int            ack_cnt  = 0;
    bit            mem_pend = 1'b0;
    logic [AW-1:0] got_addr [$];
    logic [DW-1:0] got_data [$];

    always @(negedge clk_sys) begin
        if (reset) begin
            bus.wr_ack = 1'b0;
            mem_pend   = 1'b0;
        end else begin
            if (!mem_pend && (bus.wr_req !== bus.wr_ack)) begin
                mem_pend = 1'b1;
                ack_cnt  = ack_lat;
                got_addr.push_back(bus.wr_addr);
                got_data.push_back(bus.wr_data);
            end
            if (mem_pend && !mem_hold) begin
                if (ack_cnt == 0) begin
                    bus.wr_ack = bus.wr_req;
                    mem_pend   = 1'b0;
                end else begin
                    ack_cnt--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [DW-1:0] swapped(input logic [DW-1:0] d);
        return {d[7:0], d[15:8]};
    endfunction

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic new_download();
        bus.ioctl_download = 1'b0;
        tick();
        bus.ioctl_download = 1'b1;
        tick();
    endtask

    task automatic strobe(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_data = d;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic wait_writes(input int n, input string tag);
        int k;
        k = 0;
        while ((got_addr.size() < n || bus.wr_req !== bus.wr_ack) && k < 400) begin
            tick();
            k++;
        end
        n_tests++;
        if (k >= 400) begin
            n_fail++;
            $display("FAIL %s_drain: writes seen %0d, required %0d", tag, got_addr.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({bus.ioctl_wait, bus.wr_req, overflow, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: wait/req/ovf/done=%b required 0000",
                     {bus.ioctl_wait, bus.wr_req, overflow, done});
        end
        n_tests++;
        if (bus.wr_addr !== '0 || bus.wr_data !== '0 || rom_size !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: addr=%h data=%h size=%h required 0", bus.wr_addr, bus.wr_data, rom_size);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit wait_seen;
        wait_seen = 1'b0;
        new_download();
        clear_log();
        ack_lat = 3;
        strobe(25'h000, 16'h1234);
        wait_seen |= bus.ioctl_wait;
        n_tests++;
        if (bus.wr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_req_t1: wr_req=%b required 0", bus.wr_req);
        end
        tick();
        wait_seen |= bus.ioctl_wait;
        n_tests++;
        if (bus.wr_req !== 1'b1 || bus.wr_addr !== 25'h000 || bus.wr_data !== 16'h3412) begin
            n_fail++;
            $display("FAIL single_issue_t2: req=%b addr=%h data=%h required 1 000 3412",
                     bus.wr_req, bus.wr_addr, bus.wr_data);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            wait_seen |= bus.ioctl_wait;
        end
        wait_writes(1, "single");
        n_tests++;
        if (rom_size !== 25'd2) begin
            n_fail++;
            $display("FAIL single_rom_size: rom_size=%h required 2", rom_size);
        end
        n_tests++;
        if (wait_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL single_wait: ioctl_wait rose, required to stay 0");
        end
    endtask

    task automatic test_burst_honour();
        logic [AW-1:0] ea [8];
        logic [DW-1:0] ed [8];
        int            i, k, base;
        bit            wait_seen;
        new_download();
        clear_log();
        ack_lat   = 10;
        wait_seen = 1'b0;
        base      = 2 * int'($urandom_range(0, 32'h8000));
        for (int j = 0; j < 8; j++) begin
            ea[j] = AW'(base + 2 * j);
            ed[j] = DW'($urandom);
        end
        i = 0;
        k = 0;
        while (i < 8 && k < 300) begin
            if (!bus.ioctl_wait) begin
                bus.ioctl_wr   = 1'b1;
                bus.ioctl_addr = ea[i];
                bus.ioctl_data = ed[i];
                i++;
            end else begin
                bus.ioctl_wr = 1'b0;
            end
            tick();
            k++;
            if (bus.ioctl_wait) wait_seen = 1'b1;
        end
        bus.ioctl_wr = 1'b0;
        wait_writes(8, "burst_honour");
        n_tests++;
        if (wait_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_honour_wait: ioctl_wait never rose, required 1");
        end
        n_tests++;
        if (got_addr.size() != 8) begin
            n_fail++;
            $display("FAIL burst_honour_count: writes=%0d required 8", got_addr.size());
        end
        for (int j = 0; j < 8 && j < got_addr.size(); j++) begin
            n_tests++;
            if (got_addr[j] !== ea[j] || got_data[j] !== swapped(ed[j])) begin
                n_fail++;
                $display("FAIL burst_honour_word%0d: addr=%h data=%h required %h %h",
                         j, got_addr[j], got_data[j], ea[j], swapped(ed[j]));
            end
        end
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_honour_overflow: overflow=%b required 0", overflow);
        end
    endtask

    task automatic test_burst_ignore();
        logic [AW-1:0] ea [8];
        logic [DW-1:0] ed [8];
        int            j;
        bit            in_order;
        new_download();
        clear_log();
        ack_lat = 10;
        for (int n = 0; n < 8; n++) begin
            ea[n] = AW'(32'h200 + 2 * n);
            ed[n] = DW'($urandom);
        end
        for (int n = 0; n < 8; n++) begin
            strobe(ea[n], ed[n]);
        end
        repeat (150) tick();
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_ignore_overflow: overflow=%b required 1", overflow);
        end
        n_tests++;
        if (got_addr.size() < DEPTH || got_addr.size() > 7) begin
            n_fail++;
            $display("FAIL burst_ignore_count: writes=%0d required %0d..7", got_addr.size(), DEPTH);
        end
        in_order = 1'b1;
        j = 0;
        for (int g = 0; g < got_addr.size(); g++) begin
            while (j < 8 && (got_addr[g] !== ea[j] || got_data[g] !== swapped(ed[j]))) j++;
            if (j >= 8) in_order = 1'b0;
            j++;
        end
        n_tests++;
        if (in_order !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_ignore_order: written words are not an ordered subset of the strobes");
        end
        repeat (5) tick();
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_ignore_sticky: overflow=%b required 1", overflow);
        end
        new_download();
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_ignore_clear: overflow=%b required 0", overflow);
        end
    endtask

    task automatic test_rom_size();
        logic [AW-1:0] model;
        logic [AW-1:0] a;
        new_download();
        clear_log();
        ack_lat = 0;
        strobe(25'h100, DW'($urandom));
        tick();
        strobe(25'h010, DW'($urandom));
        wait_writes(2, "rom_size_fixed");
        n_tests++;
        if (rom_size !== 25'h102) begin
            n_fail++;
            $display("FAIL rom_size_fixed: rom_size=%h required 102", rom_size);
        end
        model = 25'h102;
        for (int n = 0; n < 6; n++) begin
            a = AW'(2 * $urandom_range(0, 32'h2000));
            if (a + 25'd2 > model) model = a + 25'd2;
            strobe(a, DW'($urandom));
            repeat (3) tick();
        end
        wait_writes(8, "rom_size_rand");
        n_tests++;
        if (rom_size !== model) begin
            n_fail++;
            $display("FAIL rom_size_rand: rom_size=%h required %h", rom_size, model);
        end
        new_download();
        n_tests++;
        if (rom_size !== '0) begin
            n_fail++;
            $display("FAIL rom_size_clear: rom_size=%h required 0", rom_size);
        end
    endtask

    task automatic test_done();
        int pulses;
        bit early;
        new_download();
        clear_log();
        ack_lat = 4;
        pulses  = 0;
        early   = 1'b0;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h040;
        bus.ioctl_data = DW'($urandom);
        tick();
        bus.ioctl_addr = 25'h042;
        bus.ioctl_data = DW'($urandom);
        tick();
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (done === 1'b1) begin
                pulses++;
                if (got_addr.size() != 2 || bus.wr_req !== bus.wr_ack) early = 1'b1;
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL done_pulses: pulses=%0d required 1", pulses);
        end
        n_tests++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL done_early: done asserted before last ack, required after drain");
        end
        n_tests++;
        if (got_addr.size() != 2) begin
            n_fail++;
            $display("FAIL done_writes: writes=%0d required 2", got_addr.size());
        end
    endtask

    task automatic test_reset_busy();
        int            k;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bus.ioctl_download = 1'b1;
        tick();
        clear_log();
        mem_hold = 1'b1;
        strobe(25'h080, DW'($urandom));
        k = 0;
        while (bus.wr_req === bus.wr_ack && k < 10) begin
            tick();
            k++;
        end
        n_tests++;
        if (bus.wr_req === bus.wr_ack) begin
            n_fail++;
            $display("FAIL reset_busy_issue: wr_req=%b wr_ack=%b required differing", bus.wr_req, bus.wr_ack);
        end
        strobe(25'h082, DW'($urandom));
        reset = 1'b1;
        tick();
        n_tests++;
        if ({bus.ioctl_wait, bus.wr_req, bus.wr_ack, overflow, done} !== 5'b00000 ||
            bus.wr_addr !== '0 || bus.wr_data !== '0 || rom_size !== '0) begin
            n_fail++;
            $display("FAIL reset_busy_outputs: wait/req/ack/ovf/done=%b addr=%h data=%h size=%h required all 0",
                     {bus.ioctl_wait, bus.wr_req, bus.wr_ack, overflow, done}, bus.wr_addr, bus.wr_data, rom_size);
        end
        reset    = 1'b0;
        mem_hold = 1'b0;
        ack_lat  = 2;
        tick();
        clear_log();
        a = AW'(2 * $urandom_range(0, 32'h1000));
        d = DW'($urandom);
        strobe(a, d);
        tick();
        n_tests++;
        if (bus.wr_req !== 1'b1 || bus.wr_addr !== a || bus.wr_data !== swapped(d)) begin
            n_fail++;
            $display("FAIL reset_busy_fresh: req=%b addr=%h data=%h required 1 %h %h",
                     bus.wr_req, bus.wr_addr, bus.wr_data, a, swapped(d));
        end
        wait_writes(1, "reset_busy");
        repeat (10) tick();
        n_tests++;
        if (got_addr.size() != 1) begin
            n_fail++;
            $display("FAIL reset_busy_fifo_empty: writes=%0d required 1", got_addr.size());
        end
    endtask

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_data     = '0;
        test_reset();
        test_single();
        test_burst_honour();
        test_burst_ignore();
        test_rom_size();
        test_done();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
